// File: rtl/usb3_ep_in_packetizer_pkg.sv
// Shared types and constants for the USB3 IN-endpoint packetizer.
package usb3_ep_in_packetizer_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FILL     = 2'd1,
    DRAIN    = 2'd2,
    WAIT_ACK = 2'd3
  } pktState_e;

  localparam int DEF_MAX_PKT_BYTES = 1024;
  localparam int DEF_ADDR_WIDTH    = 9;
  localparam int DEF_ACK_TIMEOUT   = 4095;
  localparam int LEN_WIDTH         = 11;
  localparam int WORD_CNT_WIDTH    = 9;

  // A lastBytes of 0 means the final word carried all four bytes.
  function automatic logic [LEN_WIDTH-1:0] pktLen(input logic [WORD_CNT_WIDTH-1:0] words,
                                                  input logic [1:0] lastBytes);
    logic [LEN_WIDTH-1:0] full;
    full = {words, 2'b00};
    if (lastBytes == 2'd0) return full;
    return full - LEN_WIDTH'(3'd4 - {1'b0, lastBytes});
  endfunction

endpackage

// File: rtl/usb3_ep_in_packetizer_if.sv
// Stream-in and endpoint-buffer-out signal bundle of the packetizer.
interface usb3_ep_in_packetizer_if #(
  parameter int ADDR_WIDTH = 9
);

  logic [31:0]           strm_data;
  logic                  strm_valid;
  logic                  strm_last;
  logic [1:0]            strm_last_bytes;
  logic                  strm_ready;
  logic [ADDR_WIDTH-1:0] buf_in_addr;
  logic [31:0]           buf_in_data;
  logic                  buf_in_wren;
  logic                  buf_in_ready;
  logic                  buf_in_commit;
  logic [10:0]           buf_in_commit_len;
  logic                  buf_in_commit_ack;

  modport master (
    input  strm_data, strm_valid, strm_last, strm_last_bytes, buf_in_ready, buf_in_commit_ack,
    output strm_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len
  );

  modport slave (
    output strm_data, strm_valid, strm_last, strm_last_bytes, buf_in_ready, buf_in_commit_ack,
    input  strm_ready, buf_in_addr, buf_in_data, buf_in_wren, buf_in_commit, buf_in_commit_len
  );

endinterface

// File: rtl/usb3_ep_in_packetizer.sv
// Packs a 32-bit valid/ready stream into endpoint buffer packets, closing on
// strm_last or the packet size limit, then commits the length and waits for ack.
module usb3_ep_in_packetizer
  import usb3_ep_in_packetizer_pkg::*;
#(
  parameter int MAX_PKT_BYTES = DEF_MAX_PKT_BYTES,
  parameter int ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int ACK_TIMEOUT   = DEF_ACK_TIMEOUT
) (
  input  logic                    local_clk,
  input  logic                    reset,
  usb3_ep_in_packetizer_if.master ep,
  input  logic                    zlp_req_i,
  output logic                    zlp_ack_o,
  output logic [15:0]             pkt_count_o,
  output logic                    err_timeout_o
);

  localparam int MAX_WORDS = MAX_PKT_BYTES / 4;
  localparam int TMR_WIDTH = $clog2(ACK_TIMEOUT + 1);
  localparam logic [WORD_CNT_WIDTH-1:0] LAST_WORD = WORD_CNT_WIDTH'(MAX_WORDS - 1);
  localparam logic [TMR_WIDTH-1:0]      TMR_LAST  = TMR_WIDTH'(ACK_TIMEOUT - 1);

  pktState_e                 state_q, state_d;
  logic [WORD_CNT_WIDTH-1:0] wordCnt_q, wordCnt_d;
  logic [1:0]                lastBytes_q, lastBytes_d;
  logic [LEN_WIDTH-1:0]      len_q, len_d;
  logic                      zlp_q, zlp_d;
  logic [TMR_WIDTH-1:0]      tmr_q, tmr_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [31:0]               data_q, data_d;
  logic                      wren_q, wren_d;
  logic [15:0]               pktCount_q, pktCount_d;
  logic                      zlpAck_q, zlpAck_d;
  logic                      errTimeout_q, errTimeout_d;

  logic strmReady;
  logic commit;
  logic handshake;
  logic closePkt;
  logic timedOut;

  assign handshake = ep.strm_valid & strmReady;
  // The limit check uses the pre-increment count, so the word that fills the
  // packet closes it and strm_ready is already low in the following cycle.
  assign closePkt  = handshake & (ep.strm_last | (wordCnt_q == LAST_WORD));
  assign timedOut  = (tmr_q == TMR_LAST);

  always_ff @(posedge local_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      wordCnt_q    <= '0;
      lastBytes_q  <= '0;
      len_q        <= '0;
      zlp_q        <= 1'b0;
      tmr_q        <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      wren_q       <= 1'b0;
      pktCount_q   <= '0;
      zlpAck_q     <= 1'b0;
      errTimeout_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wordCnt_q    <= wordCnt_d;
      lastBytes_q  <= lastBytes_d;
      len_q        <= len_d;
      zlp_q        <= zlp_d;
      tmr_q        <= tmr_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      wren_q       <= wren_d;
      pktCount_q   <= pktCount_d;
      zlpAck_q     <= zlpAck_d;
      errTimeout_q <= errTimeout_d;
    end
  end

  // A pending ZLP request wins over stream data whenever the buffer is granted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (ep.buf_in_ready) state_d = zlp_req_i ? WAIT_ACK : FILL;
      FILL:     if (closePkt) state_d = DRAIN;
      DRAIN:    state_d = WAIT_ACK;
      WAIT_ACK: if (ep.buf_in_commit_ack || timedOut) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    wordCnt_d    = wordCnt_q;
    lastBytes_d  = lastBytes_q;
    len_d        = len_q;
    zlp_d        = zlp_q;
    tmr_d        = tmr_q;
    addr_d       = addr_q;
    data_d       = data_q;
    wren_d       = 1'b0;
    pktCount_d   = pktCount_q;
    zlpAck_d     = 1'b0;
    errTimeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        wordCnt_d   = '0;
        lastBytes_d = '0;
        tmr_d       = '0;
        zlp_d       = ep.buf_in_ready & zlp_req_i;
        if (ep.buf_in_ready && zlp_req_i) len_d = '0;
      end
      FILL: begin
        if (handshake) begin
          addr_d      = wordCnt_q[ADDR_WIDTH-1:0];
          data_d      = ep.strm_data;
          wren_d      = 1'b1;
          wordCnt_d   = wordCnt_q + 1'b1;
          lastBytes_d = ep.strm_last ? ep.strm_last_bytes : 2'd0;
        end
      end
      DRAIN: begin
        len_d = pktLen(wordCnt_q, lastBytes_q);
        tmr_d = '0;
      end
      WAIT_ACK: begin
        // Ack in the expiry cycle still counts as a successful commit.
        if (ep.buf_in_commit_ack) begin
          pktCount_d = pktCount_q + 16'd1;
          zlpAck_d   = zlp_q;
          zlp_d      = 1'b0;
        end else if (timedOut) begin
          errTimeout_d = 1'b1;
          zlp_d        = 1'b0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    strmReady = (state_q == FILL);
    commit    = (state_q == WAIT_ACK);
  end

  assign ep.strm_ready        = strmReady;
  assign ep.buf_in_addr       = addr_q;
  assign ep.buf_in_data       = data_q;
  assign ep.buf_in_wren       = wren_q;
  assign ep.buf_in_commit     = commit;
  assign ep.buf_in_commit_len = len_q;
  assign zlp_ack_o            = zlpAck_q;
  assign pkt_count_o          = pktCount_q;
  assign err_timeout_o        = errTimeout_q;

endmodule
